// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: conditions the raw lines, assembles 11-bit
// frames and folds E0/F0 prefixes into ext/break flags on a single key event.
//
// Output protocol: key_valid and frame_err are one-cycle strobes with no
// ready input. key_code/key_ext/key_break change only in the cycle
// key_valid is high and hold otherwise, so the consumer must sample them
// on key_valid. The two strobes are never high together.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t state, state_n;

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] hist;
  logic                  clk_f, clk_f_d;
  logic                  fall;
  logic                  d_s;
  logic [7:0]            shreg;
  logic [2:0]            bitcnt;
  logic                  par;
  logic [TW-1:0]         tcnt;
  logic                  ext_pend, brk_pend;
  logic                  byte_ok, byte_bad, tmo;

  // Two-flop synchronisers; idle level of both lines is high.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the filtered clock only moves once the whole history agrees.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '1;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      hist    <= {hist[FILTER_LEN-2:0], clk_s2};
      clk_f_d <= clk_f;
      if (hist == '0) begin
        clk_f <= 1'b0;
      end else if (&hist) begin
        clk_f <= 1'b1;
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;
  assign d_s  = dat_s2;

  // Frame state register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus accept/reject/timeout decisions; a fall beats a timeout.
  always_comb begin
    state_n  = state;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    tmo      = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!d_s) state_n = DATA;
        DATA:    if (bitcnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (d_s && (^{shreg, par})) byte_ok = 1'b1;
          else                        byte_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TMO_LAST) begin
      tmo     = 1'b1;
      state_n = IDLE;
    end
  end

  // Bit shifter, bit counter, parity latch and inactivity counter.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= 8'h00;
      bitcnt <= 3'd0;
      par    <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (fall) begin
        case (state)
          IDLE:   bitcnt <= 3'd0;
          DATA: begin
            shreg  <= {d_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY: par <= d_s;
          default: ;
        endcase
      end
      if (fall || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Prefix folding and registered event/error strobes.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (byte_ok) begin
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          key_code  <= shreg;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          key_valid <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end else if (byte_bad || tmo) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frames are driven bit by bit,
// expected events are queued as {err, code, ext, brk} and checked by a monitor.
module tb_ps2_scancode_receiver;

  localparam int W = 11;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall_cyc = 0;
  int err_cyc = 0;

  ps2_scancode_receiver #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(2000)
  ) dut (
    .clkin    (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare whenever a strobe is presented
  always @(negedge clk) begin
    if (rst_n && (key_valid || frame_err)) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      act = {frame_err, key_code, key_ext, key_break};
      if (frame_err) err_cyc = cyc;
      total++;
      if (key_valid && frame_err) begin
        bad++;
        $display("FAIL both_strobes: key_valid=1 frame_err=1 required not both");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got err=%0b code=%02h ext=%0b brk=%0b, required none",
                 act[10], act[9:2], act[1], act[0]);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL event: got err=%0b code=%02h ext=%0b brk=%0b, required err=%0b code=%02h ext=%0b brk=%0b",
                   act[10], act[9:2], act[1], act[0], exp[10], exp[9:2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic push_exp(input logic err, input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({err, code, ext, brk});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a 50-cycle low phase.
  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_data = b;
    repeat (20) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (50) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ par_flip, glitch);
    send_bit(1'b1, glitch);
    ps2_data = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_key_code"},  {24'h0, key_code}, 32'h00);
    check({tag, "_key_ext"},   {31'h0, key_ext},   32'h0);
    check({tag, "_key_break"}, {31'h0, key_break}, 32'h0);
    check({tag, "_key_valid"}, {31'h0, key_valid}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
  endtask

  initial begin
    logic [7:0] b1c;
    b1c = 8'h1C;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // plain make code
    push_exp(1'b0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // break prefix
    push_exp(1'b0, 8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // extended break, then flags return to 0
    push_exp(1'b0, 8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    push_exp(1'b0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // parity error clears the pending break
    push_exp(1'b1, 8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    push_exp(1'b0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // truncated frame times out
    push_exp(1'b1, 8'h1C, 1'b0, 1'b0);
    err_cyc = 0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b1c[i], 1'b0);
    ps2_data = 1'b1;
    repeat (2200) @(negedge clk);
    total++;
    if ((err_cyc - last_fall_cyc) < 1990 || (err_cyc - last_fall_cyc) > 2030) begin
      bad++;
      $display("FAIL timeout_delay: got %0d cycles after last fall, required about 2000",
               err_cyc - last_fall_cyc);
    end
    push_exp(1'b0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // short clock glitches are filtered out
    push_exp(1'b0, 8'h75, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);

    // reset mid-frame discards the partial frame and the pending E0
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b1c[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    push_exp(1'b0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    repeat (50) @(negedge clk);
    check("leftover_expected", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
